// File: rtl/ram_loader_pkg.sv
// Shared sizing, FSM state encoding and length saturation for the RAM loader.
package ram_loader_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  localparam logic [ADDR_W-1:0] PARK_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_FINISH,
    ST_PARK,
    ST_VADDR,
    ST_VEN,
    ST_VCMP,
    ST_DONE
  } state_t;

  // Requested lengths above the RAM depth clamp to a full-RAM load.
  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] len);
    if (len > (ADDR_W+1)'(DEPTH)) begin
      return (ADDR_W+1)'(DEPTH);
    end
    return len;
  endfunction

endpackage

// File: rtl/ram_loader_shadow.sv
// Shadow copy of loaded bytes: write on stream accept, combinational read by index.
// Latency: write visible the cycle after accept. Backpressure: none, always writable.
// Storage only; no reset, contents are valid once written.
module ram_loader_shadow
  import ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              wr_vld,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/ram_loader.sv
// Loads a byte stream into the 16x8 RAM programming port, then returns it to exec mode.
// Latency: 2 cycles/byte + 3 cycles overhead (+3 cycles/byte verify with RAM_LOADER_VERIFY_EN).
// Backpressure: o_byte_ready only in the accept state; valid may stall indefinitely.
module ram_loader
  import ram_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_length,
  input  logic              i_byte_valid,
  input  logic [DATA_W-1:0] i_byte,
  output logic              o_byte_ready,
  output logic              o_program_mode,
  output logic [DATA_W-1:0] o_program_data,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_ram_enable,
  input  logic [DATA_W-1:0] i_bus,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W-1:0] o_err_addr
);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   start_len;
  logic              last_idx;

`ifdef RAM_LOADER_VERIFY_EN
  logic              ren_q, ren_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] shadow_dat;

  ram_loader_shadow u_shadow (
    .clk     (i_clk),
    .wr_vld  (state_q == ST_ACCEPT && i_byte_valid),
    .wr_addr (idx_q),
    .wr_dat  (i_byte),
    .rd_addr (idx_q),
    .rd_dat  (shadow_dat)
  );
`else
  // Read-back bus only matters when verify is built in.
  logic unused_bus;
  assign unused_bus = ^i_bus;
`endif

  assign start_len = sat_len(i_length);
  assign last_idx  = ({1'b0, idx_q} == len_q - (ADDR_W+1)'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      mode_q     <= 1'b1;
      data_q     <= '0;
      addr_q     <= PARK_ADDR;
`ifdef RAM_LOADER_VERIFY_EN
      ren_q      <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
`ifdef RAM_LOADER_VERIFY_EN
      ren_q      <= ren_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    data_d     = data_q;
    addr_d     = addr_q;
`ifdef RAM_LOADER_VERIFY_EN
    ren_d      = ren_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          len_d = start_len;
          idx_d = '0;
`ifdef RAM_LOADER_VERIFY_EN
          err_d      = 1'b0;
          err_addr_d = '0;
`endif
          if (start_len == '0) begin
            state_d = ST_DONE;
          end else begin
            // Address stays parked, so entering program mode writes nothing.
            mode_d  = 1'b0;
            state_d = ST_ACCEPT;
          end
        end
      end
      ST_ACCEPT: begin
        if (i_byte_valid) begin
          data_d  = i_byte;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The RAM commits program_data when it sees this address change.
        addr_d = idx_q;
        if (last_idx) begin
          state_d = ST_FINISH;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_ACCEPT;
        end
      end
      ST_FINISH: begin
        mode_d  = 1'b1;
        state_d = ST_PARK;
      end
      ST_PARK: begin
        addr_d = PARK_ADDR;
`ifdef RAM_LOADER_VERIFY_EN
        idx_d   = '0;
        state_d = ST_VADDR;
`else
        state_d = ST_DONE;
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      ST_VADDR: begin
        addr_d  = idx_q;
        state_d = ST_VEN;
      end
      ST_VEN: begin
        ren_d   = 1'b1;
        state_d = ST_VCMP;
      end
      ST_VCMP: begin
        ren_d = 1'b0;
        if (!err_q && i_bus != shadow_dat) begin
          err_d      = 1'b1;
          err_addr_d = idx_q;
        end
        if (last_idx) begin
          // Re-park so the next load's first write at address 0 is a real change.
          addr_d  = PARK_ADDR;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_VADDR;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_byte_ready   = (state_q == ST_ACCEPT);
  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);
  assign o_program_mode = mode_q;
  assign o_program_data = data_q;
  assign o_address      = addr_q;

`ifdef RAM_LOADER_VERIFY_EN
  assign o_ram_enable = ren_q;
  assign o_error      = err_q;
  assign o_err_addr   = err_addr_q;
`else
  assign o_ram_enable = 1'b0;
  assign o_error      = 1'b0;
  assign o_err_addr   = '0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader with a behavioural 16x8 RAM behind it and a stream-level reference model.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_start = 1'b0;
  logic [4:0] i_length = '0;
  logic       i_byte_valid = 1'b0;
  logic [7:0] i_byte = '0;
  logic       o_byte_ready, o_program_mode, o_ram_enable, o_busy, o_done, o_error;
  logic [7:0] o_program_data, i_bus;
  logic [3:0] o_address, o_err_addr;

  ram_loader dut (
    .i_clk          (clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_length       (i_length),
    .i_byte_valid   (i_byte_valid),
    .i_byte         (i_byte),
    .o_byte_ready   (o_byte_ready),
    .o_program_mode (o_program_mode),
    .o_program_data (o_program_data),
    .o_address      (o_address),
    .o_ram_enable   (o_ram_enable),
    .i_bus          (i_bus),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_error        (o_error),
    .o_err_addr     (o_err_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural 16x8 RAM: a write happens when the address changes while in program mode.
  logic [7:0] ram [16];
  logic [3:0] prev_addr;
  int clear_req = 0, clear_ack = 0;
  int corrupt_req = 0, corrupt_ack = 0;
  int corrupt_a = 0;

  always @(posedge clk) begin
    if (clear_req != clear_ack) begin
      for (int i = 0; i < 16; i++) ram[i] <= 'x;
      clear_ack <= clear_req;
    end else if (corrupt_req != corrupt_ack) begin
      ram[corrupt_a] <= ram[corrupt_a] ^ 8'hFF;
      corrupt_ack <= corrupt_req;
    end else if (o_address != prev_addr && !o_program_mode) begin
      ram[o_address] <= o_program_data;
    end
    prev_addr <= o_address;
  end

  assign i_bus = o_ram_enable ? ram[o_address] : 8'h00;

  // Per-cycle monitor: handshake/done/busy accounting plus output rules.
  int acc_cnt = 0, done_cnt = 0, busy_cyc = 0;
  int acc_base = 0, cur_len = 0;

  always @(negedge clk) begin
    if (i_rst_n) begin
      if (i_byte_valid && o_byte_ready) begin
        acc_cnt++;
        chk("acc_within_len", 32'(acc_cnt - acc_base <= cur_len), 1);
      end
      if (o_done) done_cnt++;
      if (o_busy) busy_cyc++;
      if (!o_busy) begin
        chk("idle_ready", o_byte_ready, 0);
        chk("idle_mode", o_program_mode, 1);
        chk("idle_addr", o_address, 4'hF);
      end
      if (o_byte_ready) chk("accept_mode", o_program_mode, 0);
      if (o_done) chk("done_busy", o_busy, 1);
`ifndef RAM_LOADER_VERIFY_EN
      chk("ram_en_tied", o_ram_enable, 0);
      chk("error_tied", o_error, 0);
`endif
    end
  end

  logic [7:0] stream_q [$];

  task automatic fill_random(input int n);
    stream_q.delete();
    for (int i = 0; i < n; i++) stream_q.push_back(8'($urandom));
  endtask

  task automatic run_load(input int req_len, input bit gaps, input bit spam,
                          input int corrupt_addr, output int busy_n);
    int lsat;
    int acc0, done0, busy0, cyc;
    bit hs, dn, fired;
    logic [7:0] sent [$];
    logic [7:0] exp;
    lsat  = (req_len > 16) ? 16 : req_len;
    sent  = stream_q;
    clear_req++;
    @(posedge clk); @(posedge clk); #1;
    acc0 = acc_cnt; done0 = done_cnt; busy0 = busy_cyc;
    acc_base = acc_cnt; cur_len = lsat;
    i_length = 5'(req_len);
    i_start  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    dn = 0; cyc = 0; fired = 0;
    while (!dn && cyc < 3000) begin
      i_start  = spam && ($urandom_range(0, 3) == 0);
      i_length = 5'd9;
      i_byte_valid = (stream_q.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
      i_byte = (stream_q.size() > 0) ? stream_q[0] : 8'($urandom);
      @(negedge clk);
      hs = i_byte_valid && o_byte_ready;
      dn = o_done;
      if (corrupt_addr >= 0 && !fired && o_busy && o_program_mode) begin
        corrupt_a = corrupt_addr;
        corrupt_req++;
        fired = 1;
      end
      @(posedge clk); #1;
      if (hs) void'(stream_q.pop_front());
      cyc++;
    end
    i_byte_valid = 1'b0;
    i_start = 1'b0;
    busy_n = busy_cyc - busy0;
    chk("load_done_seen", dn, 1);
    chk("accepted_count", acc_cnt - acc0, lsat);
    chk("done_pulses", done_cnt - done0, 1);
    chk("end_mode", o_program_mode, 1);
    chk("end_addr", o_address, 4'hF);
    chk("end_busy", o_busy, 0);
    chk("left_in_stream", stream_q.size(), sent.size() - lsat);
    if (!gaps) begin
`ifdef RAM_LOADER_VERIFY_EN
      chk("busy_cycles", busy_n, (lsat == 0) ? 1 : 5 * lsat + 3);
`else
      chk("busy_cycles", busy_n, (lsat == 0) ? 1 : 2 * lsat + 3);
`endif
    end
    if (lsat > 0) chk("last_prog_data", o_program_data, sent[lsat-1]);
    for (int i = 0; i < 16; i++) begin
      exp = (i < lsat) ? sent[i] : 8'hxx;
      if (i == corrupt_addr) exp = exp ^ 8'hFF;
      chk($sformatf("ram[%0d]", i), ram[i], exp);
    end
  endtask

  int bn;
  logic [7:0] rsent [$];
  int acc0, done0, cyc;
  bit hs;

  initial begin
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_mode", o_program_mode, 1);
    chk("rst_addr", o_address, 4'hF);
    chk("rst_data", o_program_data, 0);
    chk("rst_ready", o_byte_ready, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ram_en", o_ram_enable, 0);
    chk("rst_error", o_error, 0);
    chk("rst_err_addr", o_err_addr, 0);
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;

    // Fixed four-byte load, valid every cycle.
    stream_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(4, 0, 0, -1, bn);
    chk("t1_ram0", ram[0], 8'h11);
    chk("t1_ram3", ram[3], 8'h44);
`ifdef RAM_LOADER_VERIFY_EN
    chk("t1_busy", bn, 23);
`else
    chk("t1_busy", bn, 11);
`endif

    // Full RAM with random gaps and surplus bytes.
    fill_random(18);
    run_load(16, 1, 0, -1, bn);

    // Zero length, then over-length saturation.
    fill_random(3);
    run_load(0, 0, 0, -1, bn);
    chk("l0_busy", bn, 1);
    fill_random(20);
    run_load(20, 0, 0, -1, bn);

    // Start pulses while busy are ignored.
    fill_random(5);
    run_load(3, 0, 1, -1, bn);

    // Reset in the middle of a five-byte load after two bytes.
    clear_req++;
    @(posedge clk); @(posedge clk); #1;
    fill_random(2);
    rsent = stream_q;
    acc0 = acc_cnt; done0 = done_cnt;
    acc_base = acc_cnt; cur_len = 5;
    i_length = 5'd5; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    cyc = 0;
    while (cyc < 12) begin
      i_byte_valid = stream_q.size() > 0;
      i_byte = (stream_q.size() > 0) ? stream_q[0] : 8'h00;
      @(negedge clk);
      hs = i_byte_valid && o_byte_ready;
      @(posedge clk); #1;
      if (hs) void'(stream_q.pop_front());
      cyc++;
    end
    i_byte_valid = 1'b0;
    chk("rst_mid_accepted", acc_cnt - acc0, 2);
    chk("rst_mid_ready_before", o_byte_ready, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_mid_mode", o_program_mode, 1);
    chk("rst_mid_ready", o_byte_ready, 0);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_addr", o_address, 4'hF);
    repeat (2) @(posedge clk);
    #1 i_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_ram0", ram[0], rsent[0]);
    chk("rst_mid_ram1", ram[1], rsent[1]);
    for (int i = 2; i < 5; i++) chk($sformatf("rst_mid_ram%0d", i), ram[i], 8'hxx);
    chk("rst_mid_no_done", done_cnt - done0, 0);

    // Clean load after the aborted one, then random loads.
    fill_random(5);
    run_load(5, 1, 0, -1, bn);
    for (int k = 0; k < 5; k++) begin
      int l;
      l = $urandom_range(0, 20);
      fill_random(l + $urandom_range(0, 3));
      run_load(l, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1, bn);
    end

`ifdef RAM_LOADER_VERIFY_EN
    // Corrupt one word after programming; the compare pass must flag it.
    fill_random(6);
    run_load(6, 0, 0, 2, bn);
    chk("verify_error", o_error, 1);
    chk("verify_err_addr", o_err_addr, 2);
    fill_random(3);
    run_load(3, 1, 0, -1, bn);
    chk("verify_error_cleared", o_error, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
